// File: rtl/decoder_pkg.sv
// ============================================================================
// Module  : decoder_pkg
// Brief   : Shared state encoding, widths and one-hot helper for decoder3x8_strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] onehot3to8(input logic [CODE_W-1:0] code);
        return OUT_W'(1) << code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder3x8_strobe_dec.sv
// ============================================================================
// Module  : decoder3x8
// Brief   : Combinational 3-to-8 decoder; all-zero output when en is low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder3x8
    import decoder_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  y
);

    assign y = en ? onehot3to8(code) : '0;

endmodule

`default_nettype wire

// File: rtl/decoder3x8_strobe.sv
// ============================================================================
// Module  : decoder3x8_strobe
// Brief   : Handshaked 3-to-8 one-hot select driver with programmable hold
//           time and break-before-make gap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder3x8_strobe
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               quiet_gap_q, quiet_gap_d;
    logic [OUT_W-1:0]   dec_y;
    logic               accept;

    assign in_ready = en && (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    decoder3x8 u_dec (
        .en   (accept),
        .code (in_code),
        .y    (dec_y)
    );

    // quiet_gap marks a gap entered through an abort: it must not end in done.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        quiet_gap_d = quiet_gap_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d         = dec_y;
                    y_valid_d   = 1'b1;
                    cnt_d       = HOLD_LOAD;
                    quiet_gap_d = 1'b0;
                    state_d     = DRIVE;
                end
            end

            DRIVE: begin
                if (!en) begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    aborted_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        cnt_d       = GAP_LOAD;
                        quiet_gap_d = 1'b1;
                        state_d     = GAP;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_d      = !quiet_gap_q;
                    quiet_gap_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                y_d         = '0;
                y_valid_d   = 1'b0;
                quiet_gap_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            quiet_gap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            quiet_gap_q <= quiet_gap_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder3x8_strobe.sv
// ============================================================================
// Module  : tb_decoder3x8_strobe
// Brief   : Directed self-checking bench for decoder3x8_strobe (HOLD=4/GAP=1
//           and HOLD=1/GAP=0 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder3x8_strobe;

    typedef struct packed {
        logic       en;
        logic       vld;
        logic [2:0] code;
        logic [7:0] y;
        logic       yv;
        logic       busy;
        logic       rdy;
        logic       done;
        logic       ab;
    } vec_t;

    logic       clk;
    logic       rst_n;

    logic       en_a, vld_a;
    logic [2:0] code_a;
    logic       rdy_a, yv_a, busy_a, done_a, ab_a;
    logic [7:0] y_a;

    logic       en_b, vld_b;
    logic [2:0] code_b;
    logic       rdy_b, yv_b, busy_b, done_b, ab_b;
    logic [7:0] y_b;

    int tests_run    = 0;
    int tests_failed = 0;

    decoder3x8_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .in_valid(vld_a), .in_code(code_a),
        .in_ready(rdy_a), .y(y_a), .y_valid(yv_a), .busy(busy_a),
        .done(done_a), .aborted(ab_a)
    );

    decoder3x8_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(vld_b), .in_code(code_b),
        .in_ready(rdy_b), .y(y_b), .y_valid(yv_b), .busy(busy_b),
        .done(done_b), .aborted(ab_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic vld, input logic [2:0] code,
                                input logic [7:0] y, input logic yv, input logic busy,
                                input logic rdy, input logic done, input logic ab);
        vec_t v;
        v.en = en; v.vld = vld; v.code = code; v.y = y; v.yv = yv;
        v.busy = busy; v.rdy = rdy; v.done = done; v.ab = ab;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input vec_t v, input logic [7:0] ay,
                              input logic ayv, input logic abusy, input logic ardy,
                              input logic adone, input logic aab);
        chk({nm, ".y"},       ay,          v.y);
        chk({nm, ".y_valid"}, {7'd0, ayv}, {7'd0, v.yv});
        chk({nm, ".busy"},    {7'd0, abusy}, {7'd0, v.busy});
        chk({nm, ".in_ready"},{7'd0, ardy}, {7'd0, v.rdy});
        chk({nm, ".done"},    {7'd0, adone}, {7'd0, v.done});
        chk({nm, ".aborted"}, {7'd0, aab}, {7'd0, v.ab});
    endtask

    task automatic step_a(input string nm, input vec_t v);
        @(negedge clk);
        en_a = v.en; vld_a = v.vld; code_a = v.code;
        @(posedge clk);
        #1;
        check_outs(nm, v, y_a, yv_a, busy_a, rdy_a, done_a, ab_a);
    endtask

    task automatic step_b(input string nm, input vec_t v);
        @(negedge clk);
        en_b = v.en; vld_b = v.vld; code_b = v.code;
        @(posedge clk);
        #1;
        check_outs(nm, v, y_b, yv_b, busy_b, rdy_b, done_b, ab_b);
    endtask

    vec_t tbl [13];

    initial begin
        // single code 5, then abort of code 7 on its second drive cycle
        tbl[0]  = mk(1, 1, 3'd5, 8'h20, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 3'd0, 8'h20, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 3'd0, 8'h20, 1, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 3'd0, 8'h20, 1, 1, 0, 0, 0);
        tbl[4]  = mk(1, 0, 3'd0, 8'h00, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 1, 0);
        tbl[6]  = mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 1, 3'd7, 8'h80, 1, 1, 0, 0, 0);
        tbl[8]  = mk(1, 0, 3'd0, 8'h80, 1, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 3'd0, 8'h00, 0, 1, 0, 0, 1);
        tbl[10] = mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 3'd1, 8'h00, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0);

        rst_n = 1'b0;
        en_a = 1'b0; vld_a = 1'b0; code_a = 3'd0;
        en_b = 1'b0; vld_b = 1'b0; code_b = 3'd0;

        #12;
        check_outs("reset", mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0),
                   y_a, yv_a, busy_a, rdy_a, done_a, ab_a);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            step_a($sformatf("tbl[%0d]", i), tbl[i]);

        // sweep all codes with in_valid held high: 4 hold, 1 gap, 1 idle cycle each
        for (int c = 0; c < 8; c++) begin
            logic [7:0] exp_y;
            exp_y = 8'h01 << c;
            for (int s = 0; s < 4; s++)
                step_a($sformatf("sweep%0d.hold%0d", c, s),
                       mk(1, 1, 3'(c), exp_y, 1, 1, 0, 0, 0));
            step_a($sformatf("sweep%0d.gap", c), mk(1, 1, 3'(c), 8'h00, 0, 1, 0, 0, 0));
            step_a($sformatf("sweep%0d.idle", c), mk(1, 1, 3'(c), 8'h00, 0, 0, 1, 1, 0));
        end

        // en low blocks acceptance, raising it accepts on the next edge
        for (int i = 0; i < 10; i++)
            step_a($sformatf("blocked%0d", i), mk(0, 1, 3'd2, 8'h00, 0, 0, 0, 0, 0));
        step_a("unblock.accept", mk(1, 1, 3'd2, 8'h04, 1, 1, 0, 0, 0));
        for (int s = 0; s < 3; s++)
            step_a($sformatf("unblock.hold%0d", s), mk(1, 0, 3'd0, 8'h04, 1, 1, 0, 0, 0));
        step_a("unblock.gap",  mk(1, 0, 3'd0, 8'h00, 0, 1, 0, 0, 0));
        step_a("unblock.done", mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 1, 0));

        // asynchronous reset in the middle of a hold
        step_a("rst.accept", mk(1, 1, 3'd6, 8'h40, 1, 1, 0, 0, 0));
        step_a("rst.hold",   mk(1, 0, 3'd0, 8'h40, 1, 1, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst.async", mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 0),
                   y_a, yv_a, busy_a, rdy_a, done_a, ab_a);
        @(negedge clk);
        rst_n = 1'b1;
        step_a("rst.after0", mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0));
        step_a("rst.after1", mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 0, 0));

        // HOLD=1, GAP=0 instance: accept every second cycle
        step_b("b.accept0", mk(1, 1, 3'd3, 8'h08, 1, 1, 0, 0, 0));
        step_b("b.done0",   mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 1, 0));
        step_b("b.accept1", mk(1, 1, 3'd3, 8'h08, 1, 1, 0, 0, 0));
        step_b("b.done1",   mk(1, 0, 3'd0, 8'h00, 0, 0, 1, 1, 0));
        step_b("b.abort",   mk(1, 1, 3'd1, 8'h02, 1, 1, 0, 0, 0));
        step_b("b.aborted", mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 1));
        step_b("b.quiet",   mk(0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
